// File: rtl/issuer_pkg.sv
// Shared widths, ROB signal kinds and the latch/dispatch record types for the issue stage.
package issuer_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned ROB_ID_W = 4;
    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned OP_W     = 6;

    // Tag 0 never names a ROB entry; it marks an operand as already resolved.
    localparam logic [ROB_ID_W-1:0] TAG_READY = '0;

    typedef enum logic [1:0] {
        KindNormal = 2'd0,
        KindBranch = 2'd1,
        KindStore  = 2'd2
    } rob_kind_e;

    typedef struct packed {
        logic                valid;
        logic [OP_W-1:0]     op;
        logic [REG_ID_W-1:0] rd;
        logic [REG_ID_W-1:0] rs1;
        logic [REG_ID_W-1:0] rs2;
        logic                uses_rs2;
        logic                is_mem;
        rob_kind_e           kind;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     next_pc;
    } instr_t;

    typedef struct packed {
        logic [OP_W-1:0]     op;
        logic [XLEN-1:0]     vj;
        logic [XLEN-1:0]     vk;
        logic [ROB_ID_W-1:0] qj;
        logic [ROB_ID_W-1:0] qk;
        logic [ROB_ID_W-1:0] dest;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     pc;
    } packet_t;

endpackage

// File: rtl/issuer_operand_resolver.sv
// Priority mux turning a source register into a value or a pending ROB tag.
module issuer_operand_resolver
    import issuer_pkg::*;
(
    input  logic [REG_ID_W-1:0] rs,
    input  logic [ROB_ID_W-1:0] rf_q,
    input  logic [XLEN-1:0]     rf_v,
    input  logic                rob_v_valid,
    input  logic [XLEN-1:0]     rob_v,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]     cdb_value,
    output logic [XLEN-1:0]     v,
    output logic [ROB_ID_W-1:0] q
);

    always_comb begin
        v = '0;
        q = TAG_READY;
        // x0 reads as zero regardless of any stale rename tag
        if (rs != '0) begin
            if (rf_q == TAG_READY) begin
                v = rf_v;
            end else if (rob_v_valid) begin
                v = rob_v;
            end else if (cdb_valid && (cdb_tag == rf_q)) begin
                v = cdb_value;
            end else begin
                q = rf_q;
            end
        end
    end

endmodule

// File: rtl/issuer.sv
// Issue stage: latches one decoded instruction, allocates a ROB entry, resolves operands,
// renames rd and dispatches a registered packet to the ALU station or load/store buffer.
module issuer
    import issuer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,

    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [OP_W-1:0]     dec_op,
    input  logic [REG_ID_W-1:0] dec_rd,
    input  logic [REG_ID_W-1:0] dec_rs1,
    input  logic [REG_ID_W-1:0] dec_rs2,
    input  logic                dec_uses_rs2,
    input  logic                dec_is_mem,
    input  logic [1:0]          dec_kind,
    input  logic [XLEN-1:0]     dec_imm,
    input  logic [XLEN-1:0]     dec_pc,
    input  logic [XLEN-1:0]     dec_next_pc,

    output logic [REG_ID_W-1:0] rf_rs1,
    output logic [REG_ID_W-1:0] rf_rs2,
    input  logic [ROB_ID_W-1:0] rf_q1,
    input  logic [ROB_ID_W-1:0] rf_q2,
    input  logic [XLEN-1:0]     rf_v1,
    input  logic [XLEN-1:0]     rf_v2,
    output logic                rf_rename_en,
    output logic [REG_ID_W-1:0] rf_rename_rd,
    output logic [ROB_ID_W-1:0] rf_rename_tag,

    input  logic                rob_full,
    output logic                rob_valid,
    output logic [1:0]          rob_signal,
    output logic [REG_ID_W-1:0] rob_rd,
    output logic [XLEN-1:0]     rob_next_pc,
    input  logic [ROB_ID_W-1:0] rob_dest,
    output logic [ROB_ID_W-1:0] rob_qj,
    output logic [ROB_ID_W-1:0] rob_qk,
    input  logic                rob_vj_valid,
    input  logic                rob_vk_valid,
    input  logic [XLEN-1:0]     rob_vj,
    input  logic [XLEN-1:0]     rob_vk,

    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]     cdb_value,

    input  logic                rs_full,
    input  logic                lsb_full,
    output logic                rs_valid,
    output logic                lsb_valid,
    output logic [OP_W-1:0]     out_op,
    output logic [XLEN-1:0]     out_vj,
    output logic [XLEN-1:0]     out_vk,
    output logic [ROB_ID_W-1:0] out_qj,
    output logic [ROB_ID_W-1:0] out_qk,
    output logic [ROB_ID_W-1:0] out_dest,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_pc
);

    instr_t  lat_q, dec_instr;
    packet_t pkt_q, pkt_d;
    logic    rs_valid_q, lsb_valid_q;
    logic    issue_fire, dec_fire, station_full;

    logic [XLEN-1:0]     vj, vk;
    logic [ROB_ID_W-1:0] qj, qk;
    logic [REG_ID_W-1:0] rs2_eff;

    assign station_full = lat_q.is_mem ? lsb_full : rs_full;
    assign issue_fire   = rdy & lat_q.valid & ~rob_full & ~station_full & ~flush;
    assign dec_ready    = rdy & ~flush & (~lat_q.valid | issue_fire);
    assign dec_fire     = dec_valid & dec_ready;

    always_comb begin
        dec_instr          = '0;
        dec_instr.valid    = 1'b1;
        dec_instr.op       = dec_op;
        dec_instr.rd       = dec_rd;
        dec_instr.rs1      = dec_rs1;
        dec_instr.rs2      = dec_rs2;
        dec_instr.uses_rs2 = dec_uses_rs2;
        dec_instr.is_mem   = dec_is_mem;
        dec_instr.kind     = rob_kind_e'(dec_kind);
        dec_instr.imm      = dec_imm;
        dec_instr.pc       = dec_pc;
        dec_instr.next_pc  = dec_next_pc;
    end

    // ROB allocation and register-file rename happen combinationally in the issue cycle.
    assign rob_valid     = issue_fire;
    assign rob_signal    = lat_q.kind;
    assign rob_rd        = lat_q.rd;
    assign rob_next_pc   = lat_q.next_pc;
    assign rob_qj        = rf_q1;
    assign rob_qk        = rf_q2;
    assign rf_rs1        = lat_q.rs1;
    assign rf_rs2        = lat_q.rs2;
    assign rf_rename_en  = issue_fire & (lat_q.kind == KindNormal) & (lat_q.rd != '0);
    assign rf_rename_rd  = lat_q.rd;
    assign rf_rename_tag = rob_dest;

    // Treating a missing rs2 as x0 makes the resolver return a ready zero.
    assign rs2_eff = lat_q.uses_rs2 ? lat_q.rs2 : '0;

    issuer_operand_resolver u_res_j (
        .rs          (lat_q.rs1),
        .rf_q        (rf_q1),
        .rf_v        (rf_v1),
        .rob_v_valid (rob_vj_valid),
        .rob_v       (rob_vj),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .v           (vj),
        .q           (qj)
    );

    issuer_operand_resolver u_res_k (
        .rs          (rs2_eff),
        .rf_q        (rf_q2),
        .rf_v        (rf_v2),
        .rob_v_valid (rob_vk_valid),
        .rob_v       (rob_vk),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .v           (vk),
        .q           (qk)
    );

    always_comb begin
        pkt_d      = '0;
        pkt_d.op   = lat_q.op;
        pkt_d.vj   = vj;
        pkt_d.vk   = vk;
        pkt_d.qj   = qj;
        pkt_d.qk   = qk;
        pkt_d.dest = rob_dest;
        pkt_d.imm  = lat_q.imm;
        pkt_d.pc   = lat_q.pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
        end else if (flush) begin
            lat_q.valid <= 1'b0;
        end else if (rdy) begin
            if (dec_fire) begin
                lat_q <= dec_instr;
            end else if (issue_fire) begin
                lat_q.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
            pkt_q       <= '0;
        end else if (flush) begin
            rs_valid_q  <= 1'b0;
            lsb_valid_q <= 1'b0;
        end else if (rdy) begin
            rs_valid_q  <= issue_fire & ~lat_q.is_mem;
            lsb_valid_q <= issue_fire & lat_q.is_mem;
            if (issue_fire) begin
                pkt_q <= pkt_d;
            end
        end
    end

    assign rs_valid  = rs_valid_q;
    assign lsb_valid = lsb_valid_q;
    assign out_op    = pkt_q.op;
    assign out_vj    = pkt_q.vj;
    assign out_vk    = pkt_q.vk;
    assign out_qj    = pkt_q.qj;
    assign out_qk    = pkt_q.qk;
    assign out_dest  = pkt_q.dest;
    assign out_imm   = pkt_q.imm;
    assign out_pc    = pkt_q.pc;

endmodule

// File: tb/tb_issuer.sv
// Directed bench for the issue stage: a cycle-level model checked every cycle plus literal pins.
module tb_issuer;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        dec_valid, dec_ready;
    logic [5:0]  dec_op;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_uses_rs2, dec_is_mem;
    logic [1:0]  dec_kind;
    logic [31:0] dec_imm, dec_pc, dec_next_pc;
    logic [4:0]  rf_rs1, rf_rs2, rf_rename_rd;
    logic [3:0]  rf_q1, rf_q2, rf_rename_tag;
    logic [31:0] rf_v1, rf_v2;
    logic        rf_rename_en;
    logic        rob_full, rob_valid;
    logic [1:0]  rob_signal;
    logic [4:0]  rob_rd;
    logic [31:0] rob_next_pc;
    logic [3:0]  rob_dest, rob_qj, rob_qk;
    logic        rob_vj_valid, rob_vk_valid;
    logic [31:0] rob_vj, rob_vk;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        rs_full, lsb_full, rs_valid, lsb_valid;
    logic [5:0]  out_op;
    logic [31:0] out_vj, out_vk, out_imm, out_pc;
    logic [3:0]  out_qj, out_qk, out_dest;

    issuer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op), .dec_rd(dec_rd),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_uses_rs2(dec_uses_rs2),
        .dec_is_mem(dec_is_mem), .dec_kind(dec_kind), .dec_imm(dec_imm), .dec_pc(dec_pc),
        .dec_next_pc(dec_next_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_q1(rf_q1), .rf_q2(rf_q2), .rf_v1(rf_v1),
        .rf_v2(rf_v2), .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd),
        .rf_rename_tag(rf_rename_tag),
        .rob_full(rob_full), .rob_valid(rob_valid), .rob_signal(rob_signal), .rob_rd(rob_rd),
        .rob_next_pc(rob_next_pc), .rob_dest(rob_dest), .rob_qj(rob_qj), .rob_qk(rob_qk),
        .rob_vj_valid(rob_vj_valid), .rob_vk_valid(rob_vk_valid), .rob_vj(rob_vj),
        .rob_vk(rob_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .rs_full(rs_full), .lsb_full(lsb_full), .rs_valid(rs_valid), .lsb_valid(lsb_valid),
        .out_op(out_op), .out_vj(out_vj), .out_vk(out_vk), .out_qj(out_qj), .out_qk(out_qk),
        .out_dest(out_dest), .out_imm(out_imm), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic checking = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: the instruction waiting to issue, and the last packet handed to a station.
    typedef struct packed {
        logic v; logic [5:0] op; logic [4:0] rd, rs1, rs2; logic u2, mem; logic [1:0] kind;
        logic [31:0] imm, pc, npc;
    } m_instr_t;
    typedef struct packed {
        logic [5:0] op; logic [31:0] vj, vk; logic [3:0] qj, qk, dest; logic [31:0] imm, pc;
    } m_pkt_t;

    m_instr_t    m_lat = '0;
    m_pkt_t      m_out = '0;
    logic        m_rs_v = 1'b0, m_lsb_v = 1'b0;
    logic        m_fire, m_ready;
    logic [31:0] m_vj, m_vk;
    logic [3:0]  m_qj, m_qk;

    // A source is ready if it is x0, unrenamed, finished in the ROB or on the CDB right now.
    function automatic void resolve(input logic [4:0] rs, input logic [3:0] tag,
                                    input logic [31:0] rfv, input logic rob_ok,
                                    input logic [31:0] robv, output logic [31:0] v,
                                    output logic [3:0] t);
        v = 32'd0;
        t = 4'd0;
        if (rs == 5'd0)                         v = 32'd0;
        else if (tag == 4'd0)                   v = rfv;
        else if (rob_ok)                        v = robv;
        else if (cdb_valid && cdb_tag == tag)   v = cdb_value;
        else                                    t = tag;
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            m_fire  = rdy && m_lat.v && !rob_full && !(m_lat.mem ? lsb_full : rs_full) && !flush;
            m_ready = rdy && !flush && (!m_lat.v || m_fire);
            chk("dec_ready", {31'd0, dec_ready}, {31'd0, m_ready});
            chk("rob_valid", {31'd0, rob_valid}, {31'd0, m_fire});
            chk("rf_rename_en", {31'd0, rf_rename_en},
                {31'd0, m_fire && m_lat.kind == 2'd0 && m_lat.rd != 5'd0});
            chk("rob_qj", {28'd0, rob_qj}, {28'd0, rf_q1});
            chk("rob_qk", {28'd0, rob_qk}, {28'd0, rf_q2});
            if (m_lat.v) chk("rf_rs1", {27'd0, rf_rs1}, {27'd0, m_lat.rs1});
            if (m_lat.v && m_lat.u2) chk("rf_rs2", {27'd0, rf_rs2}, {27'd0, m_lat.rs2});
            if (m_fire) begin
                chk("rob_signal", {30'd0, rob_signal}, {30'd0, m_lat.kind});
                chk("rob_rd", {27'd0, rob_rd}, {27'd0, m_lat.rd});
                chk("rob_next_pc", rob_next_pc, m_lat.npc);
                chk("rf_rename_rd", {27'd0, rf_rename_rd}, {27'd0, m_lat.rd});
                chk("rf_rename_tag", {28'd0, rf_rename_tag}, {28'd0, rob_dest});
            end
            chk("rs_valid", {31'd0, rs_valid}, {31'd0, m_rs_v});
            chk("lsb_valid", {31'd0, lsb_valid}, {31'd0, m_lsb_v});
            chk("out_op", {26'd0, out_op}, {26'd0, m_out.op});
            chk("out_vj", out_vj, m_out.vj);
            chk("out_vk", out_vk, m_out.vk);
            chk("out_qj", {28'd0, out_qj}, {28'd0, m_out.qj});
            chk("out_qk", {28'd0, out_qk}, {28'd0, m_out.qk});
            chk("out_dest", {28'd0, out_dest}, {28'd0, m_out.dest});
            chk("out_imm", out_imm, m_out.imm);
            chk("out_pc", out_pc, m_out.pc);

            resolve(m_lat.rs1, rf_q1, rf_v1, rob_vj_valid, rob_vj, m_vj, m_qj);
            resolve(m_lat.u2 ? m_lat.rs2 : 5'd0, rf_q2, rf_v2, rob_vk_valid, rob_vk, m_vk, m_qk);
            if (rst) begin
                m_lat = '0; m_out = '0; m_rs_v = 1'b0; m_lsb_v = 1'b0;
            end else if (flush) begin
                m_lat.v = 1'b0; m_rs_v = 1'b0; m_lsb_v = 1'b0;
            end else if (rdy) begin
                m_rs_v  = m_fire && !m_lat.mem;
                m_lsb_v = m_fire && m_lat.mem;
                if (m_fire)
                    m_out = '{m_lat.op, m_vj, m_vk, m_qj, m_qk, rob_dest, m_lat.imm, m_lat.pc};
                if (dec_valid && m_ready)
                    m_lat = '{1'b1, dec_op, dec_rd, dec_rs1, dec_rs2, dec_uses_rs2, dec_is_mem,
                              dec_kind, dec_imm, dec_pc, dec_next_pc};
                else if (m_fire)
                    m_lat.v = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // pc is derived from the opcode so every instruction is distinguishable downstream.
    task automatic set_dec(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic u2, input logic mem,
                           input logic [1:0] kind);
        dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_uses_rs2 = u2; dec_is_mem = mem; dec_kind = kind;
        dec_imm = {26'd0, op} + 32'h100;
        dec_pc = 32'h1000 + {24'd0, op, 2'b00};
        dec_next_pc = dec_pc + 32'd4;
        dec_valid = 1'b1;
    endtask

    // Accept one instruction, let it issue, then return just after its dispatch edge.
    task automatic one(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic mem,
                       input logic [1:0] kind);
        set_dec(op, rd, rs1, rs2, u2, mem, kind);
        cyc();
        dec_valid = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; dec_valid = 1'b0;
        set_dec(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0);
        dec_valid = 1'b0;
        rf_q1 = 4'd0; rf_q2 = 4'd0; rf_v1 = 32'd0; rf_v2 = 32'd0;
        rob_full = 1'b0; rob_dest = 4'd1;
        rob_vj_valid = 1'b0; rob_vk_valid = 1'b0; rob_vj = 32'd0; rob_vk = 32'd0;
        cdb_valid = 1'b0; cdb_tag = 4'd0; cdb_value = 32'd0;
        rs_full = 1'b0; lsb_full = 1'b0;
        cyc();
        checking = 1'b1;
        cyc();
        chk("reset rs_valid", {31'd0, rs_valid}, 32'd0);
        chk("reset lsb_valid", {31'd0, lsb_valid}, 32'd0);
        chk("reset out_vj", out_vj, 32'd0);
        chk("reset dec_ready", {31'd0, dec_ready}, 32'd1);
        rst = 1'b0;
        cyc();

        // No dependencies
        rf_v1 = 32'd5; rf_v2 = 32'd7; rob_dest = 4'd3;
        set_dec(6'h01, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("t1 rob_valid", {31'd0, rob_valid}, 32'd1);
        chk("t1 rename_en", {31'd0, rf_rename_en}, 32'd1);
        chk("t1 rename_tag", {28'd0, rf_rename_tag}, 32'd3);
        cyc();
        chk("t1 rs_valid", {31'd0, rs_valid}, 32'd1);
        chk("t1 vj", out_vj, 32'd5);
        chk("t1 vk", out_vk, 32'd7);
        chk("t1 qj", {28'd0, out_qj}, 32'd0);
        chk("t1 dest", {28'd0, out_dest}, 32'd3);

        // Pending tag, then the same tag already finished in the ROB
        rf_q1 = 4'd4; rob_dest = 4'd5;
        one(6'h02, 5'd3, 5'd3, 5'd2, 1'b1, 1'b0, 2'd0);
        chk("t2 qj pending", {28'd0, out_qj}, 32'd4);
        chk("t2 vj pending", out_vj, 32'd0);
        rob_vj_valid = 1'b1; rob_vj = 32'h99;
        one(6'h03, 5'd3, 5'd3, 5'd2, 1'b1, 1'b0, 2'd0);
        chk("t2 qj rob", {28'd0, out_qj}, 32'd0);
        chk("t2 vj rob", out_vj, 32'h99);
        rf_q1 = 4'd0; rob_vj_valid = 1'b0;

        // Same-cycle CDB forward on rs2
        rf_q2 = 4'd6; cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'h1234;
        one(6'h04, 5'd4, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        chk("t3 qk", {28'd0, out_qk}, 32'd0);
        chk("t3 vk", out_vk, 32'h1234);
        cdb_valid = 1'b0;
        // rs2 pending but unused: operand k must come out ready zero
        one(6'h05, 5'd4, 5'd1, 5'd2, 1'b0, 1'b0, 2'd0);
        chk("nors2 qk", {28'd0, out_qk}, 32'd0);
        chk("nors2 vk", out_vk, 32'd0);
        rf_q2 = 4'd0;

        // ROB full holds the latched instruction and blocks the decoder
        rob_full = 1'b1;
        set_dec(6'h11, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        cyc();
        set_dec(6'h12, 5'd8, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full rob_valid", {31'd0, rob_valid}, 32'd0);
            chk("full dec_ready", {31'd0, dec_ready}, 32'd0);
            cyc();
        end
        rob_full = 1'b0;
        #1;
        chk("unfull rob_valid", {31'd0, rob_valid}, 32'd1);
        chk("unfull next_pc", rob_next_pc, 32'h1048);
        cyc();
        chk("unfull out_op", {26'd0, out_op}, 32'h11);
        dec_valid = 1'b0;
        cyc();
        chk("unfull 2nd op", {26'd0, out_op}, 32'h12);

        // Memory op stalls on a full load/store buffer even with the ALU station free
        lsb_full = 1'b1;
        set_dec(6'h13, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 2'd0);
        cyc();
        dec_valid = 1'b0;
        cyc();
        chk("lsbfull rob_valid", {31'd0, rob_valid}, 32'd0);
        chk("lsbfull lsb_valid", {31'd0, lsb_valid}, 32'd0);
        lsb_full = 1'b0;
        cyc();
        chk("lsb go", {31'd0, lsb_valid}, 32'd1);

        // Flush in an issue-eligible cycle
        set_dec(6'h14, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        cyc();
        flush = 1'b1;
        #1;
        chk("flush rob_valid", {31'd0, rob_valid}, 32'd0);
        chk("flush rename", {31'd0, rf_rename_en}, 32'd0);
        chk("flush dec_ready", {31'd0, dec_ready}, 32'd0);
        cyc();
        flush = 1'b0; dec_valid = 1'b0;
        #1;
        chk("flush rs_valid", {31'd0, rs_valid}, 32'd0);
        chk("flush dropped", {31'd0, rob_valid}, 32'd0);
        cyc();

        // x0 destination: allocate but no rename
        set_dec(6'h15, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("x0 rob_valid", {31'd0, rob_valid}, 32'd1);
        chk("x0 rename", {31'd0, rf_rename_en}, 32'd0);
        cyc();
        // rs1 = x0 ignores a stale tag
        rf_q1 = 4'd5;
        one(6'h16, 5'd2, 5'd0, 5'd2, 1'b1, 1'b0, 2'd0);
        chk("rs1x0 vj", out_vj, 32'd0);
        chk("rs1x0 qj", {28'd0, out_qj}, 32'd0);
        rf_q1 = 4'd0;
        // Store goes to LSB and never renames
        set_dec(6'h17, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 2'd2);
        cyc();
        dec_valid = 1'b0;
        #1;
        chk("store rename", {31'd0, rf_rename_en}, 32'd0);
        cyc();
        chk("store lsb_valid", {31'd0, lsb_valid}, 32'd1);
        chk("store rs_valid", {31'd0, rs_valid}, 32'd0);

        // Four back-to-back instructions give four consecutive dispatches
        for (int i = 0; i < 4; i++) begin
            set_dec(6'h21 + 6'(i), 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
            cyc();
            if (i > 0) begin
                chk("b2b rs_valid", {31'd0, rs_valid}, 32'd1);
                chk("b2b op", {26'd0, out_op}, 32'h20 + 32'(i));
            end
        end
        dec_valid = 1'b0;
        cyc();
        chk("b2b last op", {26'd0, out_op}, 32'h24);
        cyc();
        chk("b2b idle", {31'd0, rs_valid}, 32'd0);

        // rdy low freezes everything, including a dispatch strobe
        set_dec(6'h31, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        cyc();
        set_dec(6'h32, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 2'd0);
        cyc();
        rdy = 1'b0; dec_valid = 1'b0;
        #1;
        chk("rdy0 rob_valid", {31'd0, rob_valid}, 32'd0);
        cyc();
        chk("rdy0 rs_valid held", {31'd0, rs_valid}, 32'd1);
        chk("rdy0 op held", {26'd0, out_op}, 32'h31);
        rdy = 1'b1;
        cyc();
        chk("rdy1 op", {26'd0, out_op}, 32'h32);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issuer.md
Name: issuer

Overview:
- Front-end initiator of the reorder-buffer allocation/operand protocol.
- Takes one decoded instruction per cycle from the decoder and allocates a ROB entry (rd, predicted next pc, signal kind).
- Resolves rs1/rs2 through register-file rename tags, the ROB value lookup and same-cycle CDB snooping.
- Dispatches a registered packet to either the ALU reservation station or the load/store buffer, and renames rd in the register file.

Parameters:
- XLEN, 32, data/pc width.
- ROB_ID_W, 4, ROB tag width; tag 0 = "no dependency", valid tags 1..2^ROB_ID_W-1.
- REG_ID_W, 5, architectural register index width.
- OP_W, 6, internal opcode width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  mispredict flush from ROB commit.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  issuer accepts this cycle.
- dec_op  in  OP_W  opcode.
- dec_rd / dec_rs1 / dec_rs2  in  REG_ID_W  register indices.
- dec_uses_rs2  in  1  rs2 is a real operand.
- dec_is_mem  in  1  route to LSB, else ALU RS.
- dec_kind  in  2  ROB signal: 0 normal, 1 branch, 2 store.
- dec_imm / dec_pc / dec_next_pc  in  XLEN  immediate, pc, predicted next pc.
- rf_rs1 / rf_rs2  out  REG_ID_W  register-file read indices.
- rf_q1 / rf_q2  in  ROB_ID_W  rename tags.
- rf_v1 / rf_v2  in  XLEN  register-file values.
- rf_rename_en  out  1  write rename tag for rf_rename_rd.
- rf_rename_rd  out  REG_ID_W  register to rename.
- rf_rename_tag  out  ROB_ID_W  new tag.
- rob_full  in  1  ROB full.
- rob_valid  out  1  allocate entry.
- rob_signal  out  2  entry kind.
- rob_rd  out  REG_ID_W  entry rd.
- rob_next_pc  out  XLEN  entry next pc.
- rob_dest  in  ROB_ID_W  allocated tag (ROB tail).
- rob_qj / rob_qk  out  ROB_ID_W  lookup tags.
- rob_vj_valid / rob_vk_valid  in  1  ROB holds a finished value.
- rob_vj / rob_vk  in  XLEN  ROB values.
- cdb_valid  in  1  CDB broadcast.
- cdb_tag  in  ROB_ID_W  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- rs_full / lsb_full  in  1  station full.
- rs_valid / lsb_valid  out  1  registered dispatch strobe.
- out_op  out  OP_W  dispatched opcode.
- out_vj / out_vk  out  XLEN  operand values.
- out_qj / out_qk  out  ROB_ID_W  operand tags.
- out_dest  out  ROB_ID_W  destination tag.
- out_imm / out_pc  out  XLEN  immediate, pc.

Behaviour:
- State: one-entry instruction latch (lat_valid plus fields) and a registered dispatch stage.
- Reset or flush clears lat_valid, rs_valid and lsb_valid. All out_* fields reset to 0.
- issue_fire = rdy & lat_valid & !rob_full & !(lat_is_mem ? lsb_full : rs_full) & !flush.
- dec_ready = rdy & !flush & (!lat_valid | issue_fire). The latch loads on dec_valid & dec_ready.
- Simultaneous issue and accept sustains 1 instr/cycle.
- In the issue cycle the following are combinational: rob_valid=1, rob_signal/rd/next_pc from the latch, rf_rename_en = issue_fire & kind==normal & rd!=0, and rf_rename_tag = rob_dest.
- Operand j (k is identical), resolved in the issue cycle, in priority order:
  - rs1==0 → v=0, q=0.
  - rf_q1==0 → v=rf_v1, q=0.
  - rob_vj_valid → v=rob_vj, q=0.
  - cdb_valid & cdb_tag==rf_q1 → v=cdb_value, q=0.
  - else v=0, q=rf_q1.
- rob_qj = rf_q1, driven every cycle.
- If !lat_uses_rs2 → vk=0, qk=0.
- Dispatch: on the edge ending the issue cycle, out_* capture the resolved packet and out_dest=rob_dest. Exactly one of rs_valid/lsb_valid pulses high for one cycle (latency 1). Otherwise both are low next cycle.
- CDB broadcasts arriving in the dispatch cycle are the station's responsibility.
- rs1==rs2 with a pending tag yields identical qj/qk.
- Stall on full holds the latch unchanged; dec_ready stays low until the stall clears.
- rdy low: no handshakes, rob_valid and rf_rename_en low, registers hold, rs_valid/lsb_valid hold.
- Flush overrides everything in that cycle: no allocation, no rename, latch dropped.

Decomposition:
- Shared config package: XLEN, ROB_ID_W, REG_ID_W, OP_W, ROB signal-kind encodings, tag-0 "ready" constant.
- One natural sub-module, operand_resolver: a combinational priority mux instantiated twice for j and k.

Test Plan:
1. No dependencies:
   - Stimulus: rs1=1, rs2=2 with rf_q=0, rf_v=5,7; rob_dest=3.
   - Response: rob_valid pulse; next cycle rs_valid=1, vj=5, vk=7, qj=qk=0, out_dest=3; rename rd→3.
2. Pending tag:
   - Stimulus: rf_q1=4, rob_vj_valid=0, no CDB.
   - Response: out_qj=4, out_vj=0.
   - Stimulus: repeat with rob_vj_valid=1, rob_vj=0x99.
   - Response: qj=0, vj=0x99.
3. Same-cycle CDB:
   - Stimulus: rf_q2=6, cdb_valid, cdb_tag=6, cdb_value=0x1234.
   - Response: out_qk=0, out_vk=0x1234.
4. Backpressure:
   - Stimulus: rob_full=1 for 3 cycles with a latched instruction.
   - Response: no rob_valid, dec_ready=0, latch held.
   - Stimulus: rob_full released.
   - Response: issues the next cycle.
   - Stimulus: memory op with lsb_full=1, rs_full=0.
   - Response: stalls.
5. Flush:
   - Stimulus: flush asserted in an issue-eligible cycle.
   - Response: no rob_valid, no rename, lat_valid=0, rs_valid=lsb_valid=0 next cycle.
6. x0 / no-rs2 / store:
   - Stimulus: rd=0 normal.
   - Response: no rename.
   - Stimulus: rs1=0 with rf_q1=5.
   - Response: vj=0, qj=0.
   - Stimulus: store (kind=2).
   - Response: lsb_valid, rf_rename_en=0.
   - Stimulus: back-to-back 4 instructions.
   - Response: 4 consecutive dispatch cycles.
